// File: rtl/btn_debounce_if.sv
// Push-button bundle between the board pins and the pong top level.
// The master drives the raw pins; the debouncer (slave) returns the conditioned levels and pulses.
interface btn_debounce_if #(
  parameter int N = 2
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         btn_any;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_press,
    input  btn_release,
    input  btn_any
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_press,
    output btn_release,
    output btn_any
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer: synchronizes the raw pins and reports a clean level,
// single-cycle press/release pulses, and an any-pressed flag.
module btn_debounce #(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20
) (
  input logic           clk,
  input logic           reset,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [N-1:0]     POL_MASK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  // The leaving sample is the DB_CYCLES-th stable one, so the counter only has to reach DB_CYCLES-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

  logic [N-1:0]     sync_p0;
  logic [N-1:0]     sync_p1;
  state_t           state_p2 [N];
  state_t           state_nx [N];
  logic [CNT_W-1:0] cnt_p2   [N];
  logic [CNT_W-1:0] cnt_nx   [N];
  logic [N-1:0]     db_nx;
  logic [N-1:0]     db_p3;
  logic [N-1:0]     press_p3;
  logic [N-1:0]     release_p3;
  logic             any_p3;

  // Stage 0/1: polarity normalise, two-flop synchronizer (resets to "not pressed")
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.btn_raw ^ POL_MASK;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: independent debounce FSM and stability counter per channel
  always_comb begin
    db_nx = '0;
    for (int i = 0; i < N; i++) begin
      state_nx[i] = state_p2[i];
      cnt_nx[i]   = cnt_p2[i];
      case (state_p2[i])
        RELEASED: begin
          if (sync_p1[i]) begin
            state_nx[i] = WAIT_PRESS;
            cnt_nx[i]   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync_p1[i]) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = '0;
          end else if (cnt_p2[i] == CNT_LAST) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
          end else begin
            cnt_nx[i] = cnt_p2[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync_p1[i]) begin
            state_nx[i] = WAIT_RELEASE;
            cnt_nx[i]   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync_p1[i]) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
          end else if (cnt_p2[i] == CNT_LAST) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = '0;
          end else begin
            cnt_nx[i] = cnt_p2[i] + CNT_W'(1);
          end
        end
        default: begin
          state_nx[i] = RELEASED;
          cnt_nx[i]   = '0;
        end
      endcase
      db_nx[i] = (state_nx[i] == PRESSED) || (state_nx[i] == WAIT_RELEASE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_p2[i] <= RELEASED;
        cnt_p2[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state_p2[i] <= state_nx[i];
        cnt_p2[i]   <= cnt_nx[i];
      end
    end
  end

  // Stage 3: registered outputs, edges taken against the previous debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_p3      <= '0;
      press_p3   <= '0;
      release_p3 <= '0;
      any_p3     <= 1'b0;
    end else begin
      db_p3      <= db_nx;
      press_p3   <= db_nx & ~db_p3;
      release_p3 <= ~db_nx & db_p3;
      any_p3     <= |db_nx;
    end
  end

  assign bus.btn_db      = db_p3;
  assign bus.btn_press   = press_p3;
  assign bus.btn_release = release_p3;
  assign bus.btn_any     = any_p3;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: vector table, hand-written reset sequence and random bouncing pins,
// all compared every cycle against a sliding-window reference model.
module tb_btn_debounce;

  localparam int DB = 8;

  logic clk;
  logic reset;

  btn_debounce_if #(.N(2)) bus ();

  btn_debounce #(
    .N(2),
    .ACTIVE_LOW(1),
    .DB_CYCLES(DB),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a pressed sample reaches the debouncer two edges after the pin is sampled;
  // the level flips once the last DB samples all disagree with it.
  logic [1:0]    pq0, pq1;
  logic [DB-1:0] win [2];
  logic [1:0]    m_db, m_press, m_rel;

  task automatic model_reset();
    pq0 = 2'b00;
    pq1 = 2'b00;
    win[0] = '0;
    win[1] = '0;
    m_db = 2'b00;
    m_press = 2'b00;
    m_rel = 2'b00;
  endtask

  task automatic model_step();
    logic [1:0] s;
    s = pq1;
    pq1 = pq0;
    pq0 = ~bus.btn_raw;
    m_press = 2'b00;
    m_rel = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      win[ch] = {win[ch][DB-2:0], s[ch]};
      if (win[ch] == {DB{~m_db[ch]}}) begin
        m_db[ch] = ~m_db[ch];
        if (m_db[ch]) m_press[ch] = 1'b1;
        else m_rel[ch] = 1'b1;
      end
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.btn_db, bus.btn_press, bus.btn_release, bus.btn_any};
  endfunction

  function automatic logic [6:0] model_outs();
    return {m_db, m_press, m_rel, |m_db};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got db/press/rel/any=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, inputs change 1 time unit later, outputs checked on negedge.
  task automatic step(input logic [1:0] raw_n, input logic rst_val, input string name);
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    bus.btn_raw = raw_n;
    reset = rst_val;
    @(negedge clk);
    chk(name, outs(), model_outs());
  endtask

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] db;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
  } vec_t;

  vec_t tbl[$];
  logic [1:0] r;
  int hold [2];

  initial begin
    tbl.push_back('{2'b11, 50, 2'b00, 2'b00, 2'b00, 1'b0});  // idle after reset
    tbl.push_back('{2'b10, 10, 2'b00, 2'b00, 2'b00, 1'b0});  // ch0 press, still counting
    tbl.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b10, 20, 2'b01, 2'b00, 2'b00, 1'b1});  // held: no repeat
    tbl.push_back('{2'b00,  5, 2'b01, 2'b00, 2'b00, 1'b1});  // ch1 bounce
    tbl.push_back('{2'b10,  2, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b00, 10, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b00,  1, 2'b11, 2'b10, 2'b00, 1'b1});
    tbl.push_back('{2'b00,  1, 2'b11, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b10, 10, 2'b11, 2'b00, 2'b00, 1'b1});  // ch1 release
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00, 2'b10, 1'b1});
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11,  1, 2'b01, 2'b00, 2'b00, 1'b1});  // ch0 release bounce
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11,  1, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 10, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 10, 2'b00, 2'b00, 2'b00, 1'b0});  // both pins together
    tbl.push_back('{2'b00,  1, 2'b11, 2'b11, 2'b00, 1'b1});
    tbl.push_back('{2'b00,  1, 2'b11, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 10, 2'b11, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b11, 1'b0});
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b10,  7, 2'b00, 2'b00, 2'b00, 1'b0});  // glitch at count DB-2
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b10, 10, 2'b00, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 10, 2'b01, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b11,  5, 2'b00, 2'b00, 2'b00, 1'b0});

    reset = 1'b1;
    bus.btn_raw = 2'b11;
    model_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, "in_reset");
    chk("reset_state", outs(), 7'b0);
    step(2'b11, 1'b0, "reset_release");

    for (int i = 0; i < tbl.size(); i++) begin
      for (int h = 0; h < tbl[i].hold; h++) step(tbl[i].raw, 1'b0, "model_vec");
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].db, tbl[i].press, tbl[i].rel, tbl[i].any});
    end

    // ch1 pressed, ch0 mid-count (5) when reset hits; both pins held through reset
    for (int i = 0; i < 11; i++) step(2'b01, 1'b0, "rst_setup");
    chk("rst_pre_press", outs(), {2'b10, 2'b10, 2'b00, 1'b1});
    for (int i = 0; i < 9; i++) step(2'b00, 1'b0, "rst_setup");
    chk("rst_pre_count", outs(), {2'b10, 2'b00, 2'b00, 1'b1});
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async", outs(), 7'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1, "rst_held");
    step(2'b00, 1'b0, "rst_release");
    for (int i = 0; i < 9; i++) step(2'b00, 1'b0, "rst_wait");
    chk("rst_no_release", outs(), 7'b0);
    step(2'b00, 1'b0, "rst_wait");
    chk("rst_repress", outs(), {2'b11, 2'b11, 2'b00, 1'b1});

    // Random bouncing pins: mostly short bursts, occasionally long stable holds
    r = 2'b11;
    hold[0] = 0;
    hold[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          r[ch] = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                                 : int'($urandom_range(1, 9));
        end
        hold[ch]--;
      end
      step(r, 1'b0, "random");
    end

    for (int i = 0; i < 15; i++) step(2'b11, 1'b0, "drain");
    chk("final_idle", outs(), 7'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
